// File: rtl/regs_pkg.sv
// Shared defaults and types for the parametrised register file and its scoreboard.
// Holds no logic; the address type here matches the default geometry only.
package regs_pkg;

    localparam int N_DEF    = 8;
    localparam int AW_DEF   = 5;
    localparam int ZERO_REG = 0;

    // Modules re-declare this with their own AW; this alias covers the default build.
    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regs_scoreboard.sv
// Per-register outstanding-write tracker: busy vector, registered popcount, sticky error.
// busy1/busy2 are combinational from the addresses; nbusy/resv_err update on the clock edge.
module regs_scoreboard
    import regs_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          w,
    input  logic [AW-1:0] Waddr,
    input  logic          resv,
    input  logic [AW-1:0] Resv_addr,
    input  logic [AW-1:0] Raddr1,
    input  logic [AW-1:0] Raddr2,
    output logic          busy1,
    output logic          busy2,
    output logic [AW:0]   nbusy,
    output logic          resv_err
);

    localparam int NREG = 2**AW;
    typedef logic [AW-1:0] addr_t;
    localparam addr_t ZERO_ADDR = addr_t'(ZERO_REG);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     r_nbusy;
    logic            r_resv_err;

    logic w_wr_en;
    logic w_rs_en;
    logic w_same;
    logic w_inc;
    logic w_dec;
    logic w_err;

    assign w_wr_en = w && (Waddr != ZERO_ADDR);
    assign w_rs_en = resv && (Resv_addr != ZERO_ADDR);
    assign w_same  = w_wr_en && w_rs_en && (Waddr == Resv_addr);

    // Reserve is applied after the write-clear so a same-address pair leaves the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_en) begin
            w_busy_nxt[Waddr] = 1'b0;
        end
        if (w_rs_en) begin
            w_busy_nxt[Resv_addr] = 1'b1;
        end
    end

    assign w_inc = w_rs_en && !r_busy[Resv_addr];
    assign w_dec = w_wr_en && r_busy[Waddr] && !w_same;
    assign w_err = w_rs_en && r_busy[Resv_addr] && !w_same;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_busy     <= '0;
            r_nbusy    <= '0;
            r_resv_err <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_nbusy    <= r_nbusy + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
            r_resv_err <= r_resv_err | w_err;
        end
    end

    // A write landing this cycle is already bypassed to the reader, so it releases the stall now.
    always_comb begin
        busy1 = 1'b0;
        if (Raddr1 != ZERO_ADDR) begin
            busy1 = r_busy[Raddr1] && !(w && (Waddr == Raddr1));
        end
    end

    always_comb begin
        busy2 = 1'b0;
        if (Raddr2 != ZERO_ADDR) begin
            busy2 = r_busy[Raddr2] && !(w && (Waddr == Raddr2));
        end
    end

    assign nbusy    = r_nbusy;
    assign resv_err = r_resv_err;

endmodule

// File: rtl/regs_sb.sv
// Decode-stage register file: 2 combinational read ports with write-through bypass, 1 write port, %0 reads zero.
// Zero read latency; no backpressure here, the controller stalls on busy1/busy2 from the scoreboard.
module regs_sb
    import regs_pkg::*;
#(
    parameter int n  = N_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          w,
    input  logic [AW-1:0] Waddr,
    input  logic [n-1:0]  Wdata,
    input  logic [AW-1:0] Raddr1,
    input  logic [AW-1:0] Raddr2,
    output logic [n-1:0]  Rdata1,
    output logic [n-1:0]  Rdata2,
    input  logic          resv,
    input  logic [AW-1:0] Resv_addr,
    output logic          busy1,
    output logic          busy2,
    output logic [AW:0]   nbusy,
    output logic          resv_err
);

    localparam int NREG = 2**AW;
    typedef logic [AW-1:0] addr_t;
    localparam addr_t ZERO_ADDR = addr_t'(ZERO_REG);

    logic [n-1:0] r_mem [NREG];
    logic         w_wr_en;

    assign w_wr_en = w && (Waddr != ZERO_ADDR);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[Waddr] <= Wdata;
        end
    end

    // Reset gates the bypass too, so a write held during reset cannot leak onto the read ports.
    always_comb begin
        Rdata1 = '0;
        if (nReset && (Raddr1 != ZERO_ADDR)) begin
            if (w && (Waddr == Raddr1)) begin
                Rdata1 = Wdata;
            end else begin
                Rdata1 = r_mem[Raddr1];
            end
        end
    end

    always_comb begin
        Rdata2 = '0;
        if (nReset && (Raddr2 != ZERO_ADDR)) begin
            if (w && (Waddr == Raddr2)) begin
                Rdata2 = Wdata;
            end else begin
                Rdata2 = r_mem[Raddr2];
            end
        end
    end

    regs_scoreboard #(
        .AW(AW)
    ) u_scoreboard (
        .clk       (clk),
        .nReset    (nReset),
        .w         (w),
        .Waddr     (Waddr),
        .resv      (resv),
        .Resv_addr (Resv_addr),
        .Raddr1    (Raddr1),
        .Raddr2    (Raddr2),
        .busy1     (busy1),
        .busy2     (busy2),
        .nbusy     (nbusy),
        .resv_err  (resv_err)
    );

endmodule

// File: tb/tb_regs_sb.sv
// Self-checking bench for regs_sb: directed scenarios plus a write/read-back scoreboard queue.
module tb_regs_sb;

    logic       clk;
    logic       nReset;
    logic       w;
    logic [4:0] Waddr;
    logic [7:0] Wdata;
    logic [4:0] Raddr1;
    logic [4:0] Raddr2;
    logic [7:0] Rdata1;
    logic [7:0] Rdata2;
    logic       resv;
    logic [4:0] Resv_addr;
    logic       busy1;
    logic       busy2;
    logic [5:0] nbusy;
    logic       resv_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    regs_sb #(.n(8), .AW(5)) dut (
        .clk       (clk),
        .nReset    (nReset),
        .w         (w),
        .Waddr     (Waddr),
        .Wdata     (Wdata),
        .Raddr1    (Raddr1),
        .Raddr2    (Raddr2),
        .Rdata1    (Rdata1),
        .Rdata2    (Rdata2),
        .resv      (resv),
        .Resv_addr (Resv_addr),
        .busy1     (busy1),
        .busy2     (busy2),
        .nbusy     (nbusy),
        .resv_err  (resv_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (actual running, required finished)");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w = 1'b0; Waddr = '0; Wdata = '0;
        resv = 1'b0; Resv_addr = '0;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        idle();
        Raddr1 = 5'd1; Raddr2 = 5'd0;
        w = 1'b1; Waddr = 5'd1; Wdata = 8'hAA;
        #12;
        checks++;
        if (Rdata1 !== 8'h00) begin errors++; $display("FAIL reset_rdata1: got %h want 00", Rdata1); end
        checks++;
        if (nbusy !== 6'd0) begin errors++; $display("FAIL reset_nbusy: got %0d want 0", nbusy); end
        checks++;
        if (resv_err !== 1'b0) begin errors++; $display("FAIL reset_resv_err: got %b want 0", resv_err); end
        idle();
        tick();
        nReset = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        exp_t e;
        w = 1'b1; Waddr = 5'd1; Wdata = 8'd11; exp_q.push_back('{5'd1, 8'd11});
        tick();
        Waddr = 5'd2; Wdata = 8'd12; exp_q.push_back('{5'd2, 8'd12});
        tick();
        for (int a = 8; a < 16; a++) begin
            Waddr = 5'(a); Wdata = 8'($urandom_range(1, 255));
            exp_q.push_back('{5'(a), Wdata});
            tick();
        end
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            Raddr1 = e.addr; Raddr2 = e.addr;
            #1;
            checks++;
            if (Rdata1 !== e.data) begin errors++; $display("FAIL rd1_reg%0d: got %h want %h", e.addr, Rdata1, e.data); end
            checks++;
            if (Rdata2 !== e.data) begin errors++; $display("FAIL rd2_reg%0d: got %h want %h", e.addr, Rdata2, e.data); end
        end
        Raddr1 = 5'd1; Raddr2 = 5'd2;
        #1;
        checks++;
        if (Rdata1 !== 8'd11 || Rdata2 !== 8'd12) begin
            errors++; $display("FAIL dual_read: got %0d/%0d want 11/12", Rdata1, Rdata2);
        end
    endtask

    task automatic test_bypass();
        w = 1'b1; Waddr = 5'd3; Wdata = 8'h5A; Raddr1 = 5'd3; Raddr2 = 5'd4;
        #1;
        checks++;
        if (Rdata1 !== 8'h5A) begin errors++; $display("FAIL bypass_pre_edge: got %h want 5a", Rdata1); end
        checks++;
        if (Rdata2 !== 8'h00) begin errors++; $display("FAIL bypass_other_port: got %h want 00", Rdata2); end
        tick();
        idle();
        #1;
        checks++;
        if (Rdata1 !== 8'h5A) begin errors++; $display("FAIL bypass_held: got %h want 5a", Rdata1); end
    endtask

    task automatic test_zero_reg();
        w = 1'b1; Waddr = 5'd0; Wdata = 8'hFF; Raddr1 = 5'd0; Raddr2 = 5'd0;
        #1;
        checks++;
        if (Rdata1 !== 8'h00 || Rdata2 !== 8'h00) begin
            errors++; $display("FAIL zero_pre_edge: got %h/%h want 00/00", Rdata1, Rdata2);
        end
        tick();
        idle();
        #1;
        checks++;
        if (Rdata1 !== 8'h00 || Rdata2 !== 8'h00) begin
            errors++; $display("FAIL zero_post_edge: got %h/%h want 00/00", Rdata1, Rdata2);
        end
        resv = 1'b1; Resv_addr = 5'd0;
        tick();
        idle();
        checks++;
        if (nbusy !== 6'd0 || busy1 !== 1'b0 || resv_err !== 1'b0) begin
            errors++; $display("FAIL zero_resv: got nbusy=%0d busy1=%b err=%b want 0/0/0", nbusy, busy1, resv_err);
        end
    endtask

    task automatic test_scoreboard();
        resv = 1'b1; Resv_addr = 5'd4;
        tick();
        Resv_addr = 5'd5;
        tick();
        idle();
        Raddr1 = 5'd4; Raddr2 = 5'd5;
        #1;
        checks++;
        if (nbusy !== 6'd2) begin errors++; $display("FAIL sb_nbusy2: got %0d want 2", nbusy); end
        checks++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1) begin errors++; $display("FAIL sb_busy: got %b/%b want 1/1", busy1, busy2); end
        w = 1'b1; Waddr = 5'd4; Wdata = 8'd7;
        #1;
        checks++;
        if (busy1 !== 1'b0 || Rdata1 !== 8'd7 || busy2 !== 1'b1) begin
            errors++; $display("FAIL sb_write_cycle: got busy1=%b rd1=%0d busy2=%b want 0/7/1", busy1, Rdata1, busy2);
        end
        tick();
        idle();
        #1;
        checks++;
        if (nbusy !== 6'd1 || busy1 !== 1'b0 || Rdata1 !== 8'd7) begin
            errors++; $display("FAIL sb_after_write: got nbusy=%0d busy1=%b rd1=%0d want 1/0/7", nbusy, busy1, Rdata1);
        end
    endtask

    task automatic test_collision();
        resv = 1'b1; Resv_addr = 5'd6; w = 1'b1; Waddr = 5'd6; Wdata = 8'd9;
        tick();
        idle();
        Raddr1 = 5'd6;
        #1;
        checks++;
        if (busy1 !== 1'b1 || Rdata1 !== 8'd9 || nbusy !== 6'd2 || resv_err !== 1'b0) begin
            errors++; $display("FAIL coll_first: got busy=%b rd=%0d nbusy=%0d err=%b want 1/9/2/0", busy1, Rdata1, nbusy, resv_err);
        end
        resv = 1'b1; Resv_addr = 5'd6; w = 1'b1; Waddr = 5'd6; Wdata = 8'h21;
        tick();
        idle();
        #1;
        checks++;
        if (busy1 !== 1'b1 || Rdata1 !== 8'h21 || nbusy !== 6'd2 || resv_err !== 1'b0) begin
            errors++; $display("FAIL coll_busy_pair: got busy=%b rd=%h nbusy=%0d err=%b want 1/21/2/0", busy1, Rdata1, nbusy, resv_err);
        end
        resv = 1'b1; Resv_addr = 5'd6;
        tick();
        idle();
        checks++;
        if (resv_err !== 1'b1 || nbusy !== 6'd2 || busy1 !== 1'b1) begin
            errors++; $display("FAIL coll_err_set: got err=%b nbusy=%0d busy=%b want 1/2/1", resv_err, nbusy, busy1);
        end
        resv = 1'b1; Resv_addr = 5'd7; w = 1'b1; Waddr = 5'd5; Wdata = 8'h33;
        tick();
        idle();
        Raddr2 = 5'd5;
        #1;
        checks++;
        if (nbusy !== 6'd2 || busy2 !== 1'b0 || Rdata2 !== 8'h33) begin
            errors++; $display("FAIL diff_addr: got nbusy=%0d busy2=%b rd2=%h want 2/0/33", nbusy, busy2, Rdata2);
        end
        resv = 1'b1; Resv_addr = 5'd9;
        tick();
        idle();
        tick(); tick();
        checks++;
        if (resv_err !== 1'b1 || nbusy !== 6'd3) begin
            errors++; $display("FAIL err_sticky: got err=%b nbusy=%0d want 1/3", resv_err, nbusy);
        end
    endtask

    task automatic test_mid_reset();
        Raddr1 = 5'd6; Raddr2 = 5'd9;
        @(negedge clk);
        nReset = 1'b0;
        #1;
        checks++;
        if (nbusy !== 6'd0 || resv_err !== 1'b0) begin
            errors++; $display("FAIL midrst_sb: got nbusy=%0d err=%b want 0/0", nbusy, resv_err);
        end
        checks++;
        if (Rdata1 !== 8'h00 || Rdata2 !== 8'h00 || busy1 !== 1'b0) begin
            errors++; $display("FAIL midrst_reads: got %h/%h busy1=%b want 00/00/0", Rdata1, Rdata2, busy1);
        end
        #2;
        nReset = 1'b1;
        tick();
        checks++;
        if (Rdata1 !== 8'h00 || Rdata2 !== 8'h00 || nbusy !== 6'd0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL postrst_state: got %h/%h nbusy=%0d busy1=%b want 00/00/0/0", Rdata1, Rdata2, nbusy, busy1);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regs_sb.md
Name: regs_sb

Overview:
Parametrised successor to the pMIPS register file. It is a 2^AW x n register file with two read ports and one dedicated write port, which has its own address and is no longer shared with a read address. Reads use write-through bypass, and register %0 is hard-wired to zero. A per-register scoreboard tracks writes that are still outstanding from multi-cycle operations such as loads. The block sits in the decode stage: the datapath reads operands here, and the controller uses the busy flags to stall.

Parameters:
n, 8, data width in bits
AW, 5, address width; register count NREG = 2**AW (32 by default)

Ports:
clk  input  1  system clock, rising edge active
nReset  input  1  asynchronous active-low reset
w  input  1  write enable
Waddr  input  AW  write address
Wdata  input  n  write data
Raddr1  input  AW  read port 1 address
Raddr2  input  AW  read port 2 address
Rdata1  output  n  read port 1 data
Rdata2  output  n  read port 2 data
resv  input  1  reserve request: marks Resv_addr as pending
Resv_addr  input  AW  register to reserve
busy1  output  1  Raddr1 has an outstanding write
busy2  output  1  Raddr2 has an outstanding write
nbusy  output  AW+1  count of registers currently busy
resv_err  output  1  sticky error flag: reserve issued to an already-busy register

Behaviour:
- Reset (nReset low, asynchronous): all registers = 0, all busy bits = 0, nbusy = 0, resv_err = 0. Rdata1/2 = 0 while in reset.
- Write: on the rising clk edge with w = 1 and Waddr != 0, reg[Waddr] <= Wdata. Writes to %0 are ignored.
- Read is combinational with zero latency.
  - Rdata = 0 if Raddr == 0.
  - Otherwise, if w and Waddr == Raddr, Rdata = Wdata (write-through bypass).
  - Otherwise, Rdata = reg[Raddr].
  - Both ports may address the same register; each port is evaluated independently.
- Scoreboard, updated on the rising clk edge:
  - A write (w = 1, Waddr != 0) clears busy[Waddr].
  - A reserve (resv = 1, Resv_addr != 0) sets busy[Resv_addr].
  - Reserve to %0 is ignored: no busy bit and no error.
  - Simultaneous reserve and write to the same address: the reserve wins, so busy stays 1 and the data is still written. This models back-to-back loads to one register.
  - Simultaneous reserve and write to different addresses: both take effect.
- busyK = busy[RaddrK] & ~(w & Waddr == RaddrK), i.e. a write arriving this cycle releases the stall combinationally, matching the bypass. busyK = 0 when RaddrK == 0.
- nbusy is registered and equals the population count of busy bits after each edge. It is updated incrementally:
  - +1 for a reserve to a non-busy register.
  - -1 for a write to a busy register that is not reserved in the same cycle.
  - Net 0 otherwise.
  - Range 0..NREG-1, so it never wraps.
- resv_err:
  - Set on an edge where resv = 1, Resv_addr != 0, busy[Resv_addr] = 1, and there is no same-cycle write to Resv_addr.
  - Sticky; cleared only by nReset.
  - The reserve still completes (busy stays 1, nbusy unchanged).
- Reset asserted mid-operation clears everything immediately. Pending reservations are lost.

Decomposition:
- Package regs_pkg:
  - localparam defaults N_DEF = 8 and AW_DEF = 5.
  - Parametrised typedef pattern for reg_addr_t (logic [AW-1:0]).
  - ZERO_REG = 0.
- Sub-module regs_scoreboard holds the busy vector, the nbusy counter and resv_err. It takes clk, nReset, w, Waddr, resv, Resv_addr, Raddr1 and Raddr2.
- The regs_sb top holds the storage array and the bypass muxes.

Test Plan:
1. Reset, then w = 1, Waddr = 1, Wdata = 11, followed by Waddr = 2, Wdata = 12. With Raddr1 = 1 and Raddr2 = 2, Rdata1 = 11 and Rdata2 = 12 after the edges.
2. Bypass: w = 1, Waddr = 3, Wdata = 8'h5A, Raddr1 = 3 in the same cycle. Rdata1 = 8'h5A before the edge. With w = 0, Rdata1 holds 8'h5A.
3. Zero register: w = 1, Waddr = 0, Wdata = 8'hFF, with Raddr1 = Raddr2 = 0. Both reads = 0 before and after the edge. resv with Resv_addr = 0 gives nbusy = 0 and busy1 = 0.
4. Scoreboard: resv to 4, then resv to 5, giving nbusy = 2. With Raddr1 = 4, busy1 = 1. Then w to 4 with Wdata = 7: busy1 = 0 in the write cycle, Rdata1 = 7, and nbusy = 1 after the edge.
5. Collision and error:
   - resv to 6 and w to 6 with Wdata = 9 in the same cycle: busy[6] = 1, reg6 = 9, nbusy +1.
   - A further resv to 6 sets resv_err = 1, and it stays 1 across later cycles.
6. Mid-operation reset: with nbusy = 3 and resv_err = 1, pulse nReset low between edges. Immediately nbusy = 0, resv_err = 0, and all reads = 0.
